// File: rtl/seg7_sum_scan_pkg.sv
// Shared constants for the sum-to-7-segment display: glyph table, FSM states,
// and elaboration-time sizing helpers.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Active-low segments, bit order {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_GLYPH [0:9] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
        7'h24, 7'h20, 7'h0F, 7'h00, 7'h04
    };
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h7E;

    function automatic logic [6:0] seg7_glyph(input logic [3:0] d);
        if (d > 4'd9)
            return SEG_BLANK;
        return SEG_GLYPH[d];
    endfunction

    // Decimal digits needed for the largest w-bit value, i.e. ceil(w*log10(2))
    function automatic int unsigned bcd_digits(input int unsigned w);
        longint unsigned v;
        int unsigned     n;
        v = (64'd1 << w) - 64'd1;
        n = 1;
        v = v / 10;
        while (v != 0) begin
            n++;
            v = v / 10;
        end
        return n;
    endfunction

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++)
            p = p * 10;
        return p;
    endfunction

endpackage

// File: rtl/seg7_sum_scan_if.sv
// Operand/strobe inputs and display/status outputs of seg7_sum_scan.
interface seg7_sum_scan_if #(
    parameter int OPW    = 8,
    parameter int DIGITS = 3
);
    logic [OPW-1:0]    a;
    logic [OPW-1:0]    b;
    logic              load;
    logic              busy;
    logic              done;
    logic              ovf;
    logic [6:0]        seg;
    logic              dp;
    logic [DIGITS-1:0] an;

    modport master (output a, b, load, input busy, done, ovf, seg, dp, an);
    modport slave  (input a, b, load, output busy, done, ovf, seg, dp, an);
endinterface

// File: rtl/seg7_sum_scan_bin2bcd.sv
// Sequential binary-to-BCD converter: one shift-add-3 step per clock,
// BIN_W steps per conversion, done pulses the cycle after the last step.
module bin2bcd_seq #(
    parameter int BIN_W      = 9,
    parameter int BCD_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);
    localparam int            CW   = $clog2(BIN_W + 1);
    localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

    logic [BIN_W-1:0]        sh_q;
    logic [CW-1:0]           cnt_q;
    logic [4*BCD_DIGITS-1:0] bcd_q;
    logic [4*BCD_DIGITS-1:0] adj;
    logic                    busy_q;
    logic                    done_q;

    always_comb begin
        adj = bcd_q;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            bcd_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start && !busy_q) begin
                sh_q   <= bin;
                bcd_q  <= '0;
                cnt_q  <= '0;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                bcd_q <= (adj << 1) | {{(4*BCD_DIGITS-1){1'b0}}, sh_q[BIN_W-1]};
                sh_q  <= sh_q << 1;
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
endmodule

// File: rtl/seg7_sum_scan.sv
// Adds two operands on load, converts the sum to BCD and drives a multiplexed
// common-anode display with leading-zero blanking and overflow dashes.
module seg7_sum_scan
    import seg7_pkg::*;
#(
    parameter int OPW    = 8,
    parameter int DIGITS = 3,
    parameter int DIV    = 1000
) (
    input logic             clk,
    input logic             rst,
    seg7_sum_scan_if.slave  io
);
    localparam int          NBCD = bcd_digits(OPW + 1);
    localparam int          EXT  = (NBCD > DIGITS) ? NBCD : DIGITS;
    localparam int          IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int          DW   = $clog2(DIV);
    localparam logic [63:0] MAXV = pow10(DIGITS) - 64'd1;

    state_t              state_q;
    logic [OPW:0]        sum;
    logic                ovf_next_q;
    logic                cv_start;
    logic                cv_busy;
    logic                cv_done;
    logic [4*EXT-1:0]    cv_bcd;
    logic [4*DIGITS-1:0] disp_q;
    logic [4*DIGITS-1:0] disp_n;
    logic                ovf_q;
    logic                ovf_n;
    logic                busy_q;
    logic                done_q;
    logic [DW-1:0]       div_q;
    logic [IW-1:0]       idx_q;
    logic [IW-1:0]       idx_n;
    logic [6:0]          seg_q;
    logic [6:0]          seg_n;
    logic [DIGITS-1:0]   an_q;
    logic [DIGITS-1:0]   an_n;
    logic                nz;

    assign sum      = {1'b0, io.a} + {1'b0, io.b};
    assign cv_start = (state_q == IDLE) && io.load && !cv_busy;

    bin2bcd_seq #(
        .BIN_W      (OPW + 1),
        .BCD_DIGITS (EXT)
    ) u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (cv_start),
        .bin   (sum),
        .busy  (cv_busy),
        .done  (cv_done),
        .bcd   (cv_bcd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ovf_next_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            disp_q     <= '0;
        end else begin
            done_q <= 1'b0;
            disp_q <= disp_n;
            ovf_q  <= ovf_n;
            case (state_q)
                IDLE: if (cv_start) begin
                    ovf_next_q <= 64'(sum) > MAXV;
                    busy_q     <= 1'b1;
                    state_q    <= CONV;
                end
                CONV: if (cv_done) begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= COMMIT;
                end
                COMMIT:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Glyph is computed from next-cycle index and contents so seg, an and a
    // committed value all change on the same edge.
    always_comb begin
        disp_n = disp_q;
        ovf_n  = ovf_q;
        if (state_q == CONV && cv_done) begin
            disp_n = cv_bcd[4*DIGITS-1:0];
            ovf_n  = ovf_next_q;
        end

        idx_n = idx_q;
        if (div_q == DW'(DIV - 1))
            idx_n = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;

        nz = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (IW'(i) >= idx_n && disp_n[4*i +: 4] != 4'd0)
                nz = 1'b1;
        end

        if (ovf_n)
            seg_n = SEG_DASH;
        else if (!nz && idx_n != '0)
            seg_n = SEG_BLANK;
        else
            seg_n = seg7_glyph(disp_n[4*idx_n +: 4]);

        an_n = ~(DIGITS'(1) << idx_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            idx_q <= '0;
            seg_q <= SEG_GLYPH[0];
            an_q  <= ~DIGITS'(1);
        end else begin
            div_q <= (div_q == DW'(DIV - 1)) ? '0 : div_q + 1'b1;
            idx_q <= idx_n;
            seg_q <= seg_n;
            an_q  <= an_n;
        end
    end

    assign io.busy = busy_q;
    assign io.done = done_q;
    assign io.ovf  = ovf_q;
    assign io.seg  = seg_q;
    assign io.dp   = 1'b1;
    assign io.an   = an_q;
endmodule

// File: tb/tb_seg7_sum_scan.sv
// Bench for seg7_sum_scan: a 3-digit and a 2-digit instance share stimulus and
// are checked every cycle against a timeline model of the sum and scan.
module tb_seg7_sum_scan;
    localparam int OPW = 8;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [OPW-1:0] a = '0;
    logic [OPW-1:0] b = '0;
    logic load = 1'b0;
    bit   run  = 1'b0;

    int checks = 0;
    int errors = 0;
    int ndone  = 0;

    logic [6:0] glyph_tbl [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                                   7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};

    always #5 clk = ~clk;

    seg7_sum_scan_if #(.OPW(OPW), .DIGITS(3)) bus3 ();
    seg7_sum_scan_if #(.OPW(OPW), .DIGITS(2)) bus2 ();
    assign bus3.a = a;  assign bus3.b = b;  assign bus3.load = load;
    assign bus2.a = a;  assign bus2.b = b;  assign bus2.load = load;

    seg7_sum_scan #(.OPW(OPW), .DIGITS(3), .DIV(DIV)) dut3 (.clk(clk), .rst(rst), .io(bus3));
    seg7_sum_scan #(.OPW(OPW), .DIGITS(2), .DIV(DIV)) dut2 (.clk(clk), .rst(rst), .io(bus2));

    // Timeline model: phase counts edges since an accepted load
    int k = 0, phase = 0, pval = 0, mval = 0;
    bit movf3 = 0, movf2 = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= 0; phase <= 0; mval <= 0; movf3 <= 0; movf2 <= 0;
        end else begin
            k <= k + 1;
            if (phase == 0) begin
                if (load) begin
                    phase <= 1;
                    pval  <= int'(a) + int'(b);
                end
            end else if (phase == OPW + 3) begin
                phase <= 0;
            end else begin
                phase <= phase + 1;
                if (phase + 1 == OPW + 3) begin
                    mval  <= pval;
                    movf3 <= pval > 999;
                    movf2 <= pval > 99;
                end
            end
        end
    end

    function automatic logic [6:0] exp_seg(input int v, input int idx, input bit ov);
        int p = 1;
        for (int j = 0; j < idx; j++) p = p * 10;
        if (ov) return 7'h7E;
        if (idx > 0 && v < p) return 7'h7F;
        return glyph_tbl[(v / p) % 10];
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus3.done === 1'b1) ndone++;
        if (run && !rst) begin
            chk("busy3", int'(bus3.busy), int'(phase >= 1 && phase <= OPW + 2));
            chk("done3", int'(bus3.done), int'(phase == OPW + 3));
            chk("ovf3",  int'(bus3.ovf),  int'(movf3));
            chk("dp3",   int'(bus3.dp),   1);
            chk("an3",   int'(bus3.an),   int'(~(3'b001 << ((k / DIV) % 3)) & 3'b111));
            chk("seg3",  int'(bus3.seg),  int'(exp_seg(mval, (k / DIV) % 3, movf3)));
            chk("busy2", int'(bus2.busy), int'(phase >= 1 && phase <= OPW + 2));
            chk("done2", int'(bus2.done), int'(phase == OPW + 3));
            chk("ovf2",  int'(bus2.ovf),  int'(movf2));
            chk("an2",   int'(bus2.an),   int'(~(2'b01 << ((k / DIV) % 2)) & 2'b11));
            chk("seg2",  int'(bus2.seg),  int'(exp_seg(mval, (k / DIV) % 2, movf2)));
        end
    end

    task automatic do_load(input int av, input int bv);
        @(negedge clk);
        a = OPW'(av); b = OPW'(bv); load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic expect3(input logic [2:0] anw, input logic [6:0] segw, input string nm);
        bit found = 0;
        for (int i = 0; i < 16 && !found; i++) begin
            @(negedge clk);
            if (bus3.an == anw) found = 1;
        end
        if (!found) chk({nm, "_an_timeout"}, int'(bus3.an), int'(anw));
        else        chk(nm, int'(bus3.seg), int'(segw));
    endtask

    task automatic expect2(input logic [1:0] anw, input logic [6:0] segw, input string nm);
        bit found = 0;
        for (int i = 0; i < 16 && !found; i++) begin
            @(negedge clk);
            if (bus2.an == anw) found = 1;
        end
        if (!found) chk({nm, "_an_timeout"}, int'(bus2.an), int'(anw));
        else        chk(nm, int'(bus2.seg), int'(segw));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run = 1'b1;
        chk("rst_seg", int'(bus3.seg), 'h01);
        chk("rst_an",  int'(bus3.an),  'b110);
        chk("rst_busy", int'(bus3.busy), 0);
        expect3(3'b101, 7'h7F, "idle_d1");
        expect3(3'b011, 7'h7F, "idle_d2");
        expect3(3'b110, 7'h01, "idle_d0");

        do_load(200, 55);
        repeat (14) @(negedge clk);
        expect3(3'b011, 7'h12, "s255_d2");
        expect3(3'b101, 7'h24, "s255_d1");
        expect3(3'b110, 7'h24, "s255_d0");

        do_load(7, 0);
        repeat (14) @(negedge clk);
        expect3(3'b011, 7'h7F, "s7_d2");
        expect3(3'b101, 7'h7F, "s7_d1");
        expect3(3'b110, 7'h0F, "s7_d0");

        do_load(100, 5);
        repeat (14) @(negedge clk);
        expect3(3'b011, 7'h4F, "s105_d2");
        expect3(3'b101, 7'h01, "s105_d1");
        expect3(3'b110, 7'h24, "s105_d0");

        do_load(99, 1);
        repeat (14) @(negedge clk);
        chk("s100_ovf2", int'(bus2.ovf), 1);
        expect2(2'b01, 7'h7E, "s100_2d0");
        expect2(2'b10, 7'h7E, "s100_2d1");
        expect3(3'b011, 7'h4F, "s100_d2");

        do_load(255, 255);
        repeat (14) @(negedge clk);
        chk("s510_ovf3", int'(bus3.ovf), 0);
        expect3(3'b011, 7'h24, "s510_d2");
        expect3(3'b101, 7'h4F, "s510_d1");
        expect3(3'b110, 7'h01, "s510_d0");

        ndone = 0;
        do_load(12, 34);
        repeat (2) @(negedge clk);
        a = 8'd99; b = 8'd99; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (16) @(negedge clk);
        chk("reload_done_count", ndone, 1);
        expect3(3'b011, 7'h7F, "s46_d2");
        expect3(3'b101, 7'h4C, "s46_d1");
        expect3(3'b110, 7'h20, "s46_d0");

        do_load(123, 45);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", int'(bus3.busy), 0);
        chk("arst_done", int'(bus3.done), 0);
        chk("arst_seg",  int'(bus3.seg),  'h01);
        chk("arst_an",   int'(bus3.an),   'b110);
        @(negedge clk);
        rst = 1'b0;
        repeat (14) @(negedge clk);
        chk("arst_no_done", int'(bus3.done), 0);
        expect3(3'b110, 7'h01, "arst_d0");

        do_load(1, 2);
        repeat (14) @(negedge clk);
        expect3(3'b110, 7'h06, "s3_d0");
        expect3(3'b101, 7'h7F, "s3_d1");

        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
